perm_data_pack_2_1: RTL and testbench



---
 rtl/perm_data_pack_2_1.sv | 87 ++++++++
 tb/tb_perm_data_pack_2_1.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_data_pack_2_1.sv
// Serial-to-parallel feeder for the 16-lane hypercube permutation network.
// Packs 16 beats into one vector through a two-entry ping-pong buffer.
module perm_data_pack_2_1 #(
  parameter int DW    = 32,
  parameter int LANES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_dat,
  input  logic [3:0]            s_sel,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW*LANES-1:0]   t_data_dat,
  output logic [4*LANES-1:0]    t_addr_dat,
  output logic                  err_short,
  output logic                  err_long
);

  localparam int DBW = DW * LANES;
  localparam int SBW = 4 * LANES;

  logic [DBW-1:0] r_dat [2];
  logic [SBW-1:0] r_sel [2];
  logic [1:0]     r_full;
  logic           r_wp;
  logic           r_rp;
  logic [3:0]     r_lc;
  logic           r_err_short;
  logic           r_err_long;

  logic w_acc;
  logic w_lane15;
  logic w_end;
  logic w_drn;

  assign s_ready  = ~r_full[r_wp];
  assign w_acc    = s_valid & s_ready;
  assign w_lane15 = (r_lc == 4'hF);
  assign w_end    = w_acc & (w_lane15 | s_last);
  assign w_drn    = r_full[r_rp] & m_ready;

  assign m_valid    = r_full[r_rp];
  assign t_data_dat = r_dat[r_rp];
  assign t_addr_dat = r_sel[r_rp];
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dat[0]    <= '0;
      r_dat[1]    <= '0;
      r_sel[0]    <= '0;
      r_sel[1]    <= '0;
      r_full      <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_lc        <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      // Drained buffer is zeroed so a later short vector reads zero lanes.
      if (w_drn) begin
        r_dat[r_rp]  <= '0;
        r_sel[r_rp]  <= '0;
        r_full[r_rp] <= 1'b0;
        r_rp         <= ~r_rp;
      end
      if (w_acc) begin
        r_dat[r_wp][r_lc*DW +: DW] <= s_dat;
        r_sel[r_wp][r_lc*4 +: 4]   <= s_sel;
        if (w_end) begin
          r_full[r_wp] <= 1'b1;
          r_wp         <= ~r_wp;
          r_lc         <= '0;
        end else begin
          r_lc <= r_lc + 4'd1;
        end
      end
      r_err_short <= w_acc & s_last & ~w_lane15;
      r_err_long  <= w_acc & w_lane15 & ~s_last;
    end
  end

endmodule

// File: tb/tb_perm_data_pack_2_1.sv
// Scoreboard bench for perm_data_pack_2_1.
// Reference model packs queued beats into vectors at beat granularity.
module tb_perm_data_pack_2_1;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  s;
    int           cyc;
  } vec_t;

  typedef struct {
    logic [1:0] k;
    int         cyc;
  } err_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  logic         clk = 0;
  logic         reset = 1;
  logic         s_valid = 0;
  logic         s_ready;
  logic [31:0]  s_dat = 0;
  logic [3:0]   s_sel = 0;
  logic         s_last = 0;
  logic         m_valid;
  logic         m_ready = 0;
  logic [511:0] t_data_dat;
  logic [63:0]  t_addr_dat;
  logic         err_short;
  logic         err_long;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stalls = 0;
  bit lat_chk = 0;
  bit rand_mr = 0;

  vec_t  exp_q[$];
  err_t  err_q[$];
  beat_t cur[$];

  logic         hold_v = 0;
  logic [511:0] hold_d;
  logic [63:0]  hold_s;

  perm_data_pack_2_1 dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_dat(s_dat), .s_sel(s_sel), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .t_data_dat(t_data_dat), .t_addr_dat(t_addr_dat),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s act=%0h req=%0h", nm, a, e);
  endtask

  task automatic model_accept(input logic [31:0] d, input logic [3:0] s,
                              input logic l, input int c);
    beat_t b;
    vec_t  v;
    err_t  e;
    b.d = d;
    b.s = s;
    cur.push_back(b);
    if (cur.size() == 16 || l) begin
      v.d = '0;
      v.s = '0;
      foreach (cur[i]) begin
        v.d[i*32 +: 32] = cur[i].d;
        v.s[i*4 +: 4]   = cur[i].s;
      end
      v.cyc = lat_chk ? c : 0;
      exp_q.push_back(v);
      if (l && cur.size() < 16) begin
        e.k = 2'b10; e.cyc = c; err_q.push_back(e);
      end
      if (!l) begin
        e.k = 2'b01; e.cyc = c; err_q.push_back(e);
      end
      cur.delete();
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s,
                      input logic l);
    int t = 0;
    s_valid = 1; s_dat = d; s_sel = s; s_last = l;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_chk++;
      $display("FAIL send_timeout act=stalled req=accepted");
      s_valid = 0;
      return;
    end
    if (t > 0) stalls++;
    model_accept(d, s, l, cyc + 1);
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_vec(input int n, input logic [31:0] base,
                          input bit inc, input logic [3:0] sel,
                          input bit last);
    for (int i = 0; i < n; i++)
      send(inc ? base + 32'(i) : base, sel, last && (i == n - 1));
  endtask

  task automatic set_mr(input logic v);
    @(posedge clk);
    #1 m_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 512'(exp_q.size()), 512'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    cur.delete();
    exp_q.delete();
    err_q.delete();
    chk("rst_m_valid", 512'(m_valid), 512'd0);
    chk("rst_s_ready", 512'(s_ready), 512'd1);
    chk("rst_data", t_data_dat, 512'd0);
    chk("rst_sel", 512'(t_addr_dat), 512'd0);
    chk("rst_err", 512'({err_short, err_long}), 512'd0);
  endtask

  always @(negedge clk) begin
    vec_t e;
    err_t r;
    if (reset) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 512'(m_valid), 512'd1);
        chk("hold_data", t_data_dat, hold_d);
        chk("hold_sel", 512'(t_addr_dat), 512'(hold_s));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_vector act=%0h req=none", t_data_dat);
        end else begin
          e = exp_q.pop_front();
          chk("vec_data", t_data_dat, e.d);
          chk("vec_sel", 512'(t_addr_dat), 512'(e.s));
          if (e.cyc != 0) chk("vec_cycle", 512'(cyc), 512'(e.cyc));
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = t_data_dat;
      hold_s = t_addr_dat;
      if (err_short || err_long) begin
        if (err_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_err act=%0b%0b req=none",
                   err_short, err_long);
        end else begin
          r = err_q.pop_front();
          chk("err_kind", 512'({err_short, err_long}), 512'(r.k));
          chk("err_cycle", 512'(cyc), 512'(r.cyc));
        end
      end
    end
  end

  initial begin
    logic [63:0] tmp;
    @(negedge clk);
    do_reset();

    // single vector with fixed latency
    set_mr(1);
    lat_chk = 1;
    for (int i = 0; i < 16; i++)
      send(32'h1000 + 32'(i), 4'(i), i == 15);
    tmp = exp_q[0].s;
    chk("single_sel_const", 512'(tmp), 512'(64'hFEDCBA9876543210));
    wait_drain();

    // back-pressure: two buffered, third stalls
    lat_chk = 0;
    set_mr(0);
    send_vec(16, 32'hA, 0, 4'hA, 1);
    send_vec(16, 32'hB, 0, 4'hB, 1);
    chk("bp_s_ready", 512'(s_ready), 512'd0);
    chk("bp_m_valid", 512'(m_valid), 512'd1);
    fork
      begin
        repeat (6) @(posedge clk);
        #1 m_ready = 1;
      end
    join_none
    send_vec(16, 32'hC, 0, 4'hC, 1);
    wait_drain();

    // short vector into a buffer that held all ones
    lat_chk = 1;
    send_vec(16, 32'hFFFFFFFF, 0, 4'hF, 1);
    send_vec(16, 32'h0, 1, 4'h3, 1);
    send_vec(6, 32'h55, 0, 4'hF, 1);
    wait_drain();

    // long vector: 17 beats, beat 16 opens next vector
    for (int i = 0; i < 17; i++) send(32'(i), 4'(i), 0);
    for (int i = 1; i < 16; i++) send(32'(100 + i), 4'h1, i == 15);
    wait_drain();

    // reset mid-fill
    send_vec(7, 32'h700, 1, 4'h7, 0);
    do_reset();
    set_mr(1);
    send_vec(16, 32'h800, 1, 4'h8, 1);
    wait_drain();

    // reset with both buffers full
    set_mr(0);
    send_vec(16, 32'hD0, 1, 4'hD, 1);
    send_vec(16, 32'hE0, 1, 4'hE, 1);
    do_reset();
    set_mr(1);
    repeat (3) @(negedge clk);

    // streaming overlap
    stalls = 0;
    for (int v = 0; v < 4; v++)
      for (int i = 0; i < 16; i++)
        send(32'(v * 16 + i), 4'(v + i), i == 15);
    chk("stream_stalls", 512'(stalls), 512'd0);
    wait_drain();

    // random traffic with random back-pressure
    lat_chk = 0;
    rand_mr = 1;
    fork
      while (rand_mr) begin
        @(posedge clk);
        #1 m_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int v = 0; v < 30; v++) begin
      int nb;
      nb = $urandom_range(1, 17);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send($urandom, 4'($urandom), (b == nb - 1) && (nb <= 16));
      end
    end
    while (cur.size() != 0)
      send($urandom, 4'($urandom), cur.size() == 15 || cur.size() == 3);
    rand_mr = 0;
    repeat (2) @(negedge clk);
    set_mr(1);
    wait_drain();
    chk("err_q_empty", 512'(err_q.size()), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
